// File: rtl/dist_engine_pkg.sv
// rtl/dist_engine_pkg.sv - register map, FSM states and mode encodings for the distance engine
package dist_engine_pkg;

    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_STATUS    = 8'h04;
    localparam logic [7:0] OFF_RESULT_LO = 8'h08;
    localparam logic [7:0] OFF_RESULT_HI = 8'h0C;
    localparam logic [1:0] OFF_A_PAGE    = 2'b01;   // 0x40..0x7F
    localparam logic [1:0] OFF_B_PAGE    = 2'b10;   // 0x80..0xBF

    localparam logic MODE_EUCLID_SQ = 1'b0;
    localparam logic MODE_MANHATTAN = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_STATUS,
        SEL_RES_LO,
        SEL_RES_HI,
        SEL_A,
        SEL_B
    } reg_sel_t;

    typedef struct packed {
        reg_sel_t   sel;
        logic [3:0] idx;
    } reg_dec_t;

    // Map a byte offset to a register; element pages only hit for indices below dim
    function automatic reg_dec_t decode_addr(input logic [7:0] off, input logic hi_zero, input int dim);
        reg_dec_t d;
        d.sel = SEL_NONE;
        d.idx = off[5:2];
        if (hi_zero && off[1:0] == 2'b00) begin
            if (off == OFF_CTRL)
                d.sel = SEL_CTRL;
            else if (off == OFF_STATUS)
                d.sel = SEL_STATUS;
            else if (off == OFF_RESULT_LO)
                d.sel = SEL_RES_LO;
            else if (off == OFF_RESULT_HI)
                d.sel = SEL_RES_HI;
            else if (off[7:6] == OFF_A_PAGE && int'({28'd0, off[5:2]}) < dim)
                d.sel = SEL_A;
            else if (off[7:6] == OFF_B_PAGE && int'({28'd0, off[5:2]}) < dim)
                d.sel = SEL_B;
        end
        return d;
    endfunction

endpackage

// File: rtl/dist_acc_unit.sv
// rtl/dist_acc_unit.sv - abs-diff, square/select and accumulate datapath
module dist_acc_unit
    import dist_engine_pkg::*;
#(
    parameter int ELEM_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              en,
    input  logic              mode,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ELEM_W-1:0]   diff;
    logic [2*ELEM_W-1:0] diff_sq;
    logic [ACC_W-1:0]    term;

    // Per-element contribution: |a-b| squared, or taken as-is in Manhattan mode
    always_comb begin
        diff    = (a >= b) ? (a - b) : (b - a);
        diff_sq = {{ELEM_W{1'b0}}, diff} * {{ELEM_W{1'b0}}, diff};
        term    = (mode == MODE_MANHATTAN) ? ACC_W'(diff) : ACC_W'(diff_sq);
    end

    // Accumulator sized so a full vector of maximal terms cannot wrap
    always_ff @(posedge clk) begin
        if (!resetn)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= acc + term;
    end

endmodule

// File: rtl/dist_engine_axil.sv
// rtl/dist_engine_axil.sv - AXI4-Lite vector distance engine (squared Euclidean / Manhattan)
module dist_engine_axil
    import dist_engine_pkg::*;
#(
    parameter int DIM                  = 8,
    parameter int ELEM_W               = 16,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 8
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     S00_AXI_AWADDR,
    input  logic                                S00_AXI_AWVALID,
    output logic                                S00_AXI_AWREADY,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     S00_AXI_WDATA,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   S00_AXI_WSTRB,
    input  logic                                S00_AXI_WVALID,
    output logic                                S00_AXI_WREADY,
    output logic [1:0]                          S00_AXI_BRESP,
    output logic                                S00_AXI_BVALID,
    input  logic                                S00_AXI_BREADY,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     S00_AXI_ARADDR,
    input  logic                                S00_AXI_ARVALID,
    output logic                                S00_AXI_ARREADY,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     S00_AXI_RDATA,
    output logic [1:0]                          S00_AXI_RRESP,
    output logic                                S00_AXI_RVALID,
    input  logic                                S00_AXI_RREADY,
    output logic                                IRQ
);

    localparam int ACC_W = 2*ELEM_W + $clog2(DIM);

    state_t              state_q, state_d;
    logic [3:0]          idx_q;
    logic                mode_q, irq_en_q, mode_run_q, done_q;
    logic [ACC_W-1:0]    result_q, acc;
    logic [63:0]         result64;
    logic [ELEM_W-1:0]   a_mem [16];
    logic [ELEM_W-1:0]   b_mem [16];
    logic                busy, acc_en, wr_fire, rd_fire, start_go;
    reg_dec_t            wr_dec, rd_dec;
    logic [31:0]         rd_data;
    logic [1:0]          rd_resp;
    logic                unused_bits;

    // Full-word writes only; strobes and the upper data bits carry no meaning here
    assign unused_bits = ^{S00_AXI_WSTRB, S00_AXI_WDATA};

    assign wr_fire  = S00_AXI_AWREADY && S00_AXI_AWVALID && S00_AXI_WVALID;
    assign rd_fire  = S00_AXI_ARREADY && S00_AXI_ARVALID;
    assign wr_dec   = decode_addr(S00_AXI_AWADDR[7:0], (S00_AXI_AWADDR >> 8) == '0, DIM);
    assign rd_dec   = decode_addr(S00_AXI_ARADDR[7:0], (S00_AXI_ARADDR >> 8) == '0, DIM);
    assign start_go = wr_fire && wr_dec.sel == SEL_CTRL && S00_AXI_WDATA[0] && state_q == S_IDLE;
    assign result64 = 64'(result_q);
    assign S00_AXI_WREADY = S00_AXI_AWREADY;

    // FSM state register
    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state: one RUN cycle per element, then a single FINISH cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_go) state_d = S_RUN;
            S_RUN:    if (idx_q == 4'(DIM-1)) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = state_q != S_IDLE;
        acc_en = state_q == S_RUN;
        IRQ    = state_q == S_FINISH && irq_en_q;
    end

    // Element index walks 0..DIM-1 while running
    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            idx_q <= '0;
        else if (start_go)
            idx_q <= '0;
        else if (state_q == S_RUN)
            idx_q <= idx_q + 4'd1;
    end

    dist_acc_unit #(
        .ELEM_W (ELEM_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk    (ACLK),
        .resetn (ARESETN),
        .clear  (start_go),
        .en     (acc_en),
        .mode   (mode_run_q),
        .a      (a_mem[idx_q]),
        .b      (b_mem[idx_q]),
        .acc    (acc)
    );

    // Write address/data accepted together, response held until taken
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            S00_AXI_AWREADY <= 1'b0;
            S00_AXI_BVALID  <= 1'b0;
            S00_AXI_BRESP   <= RESP_OKAY;
        end else begin
            S00_AXI_AWREADY <= !S00_AXI_AWREADY && !S00_AXI_BVALID && S00_AXI_AWVALID && S00_AXI_WVALID;
            if (wr_fire) begin
                S00_AXI_BVALID <= 1'b1;
                S00_AXI_BRESP  <= (wr_dec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (S00_AXI_BVALID && S00_AXI_BREADY) begin
                S00_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Register file; configuration and operands are frozen while busy
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            mode_q     <= MODE_EUCLID_SQ;
            irq_en_q   <= 1'b0;
            mode_run_q <= MODE_EUCLID_SQ;
            done_q     <= 1'b0;
            result_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else begin
            if (wr_fire && !busy) begin
                unique case (wr_dec.sel)
                    SEL_CTRL: begin
                        mode_q   <= S00_AXI_WDATA[1];
                        irq_en_q <= S00_AXI_WDATA[2];
                    end
                    SEL_A:   a_mem[wr_dec.idx] <= S00_AXI_WDATA[ELEM_W-1:0];
                    SEL_B:   b_mem[wr_dec.idx] <= S00_AXI_WDATA[ELEM_W-1:0];
                    default: ;
                endcase
            end
            if (start_go)
                mode_run_q <= S00_AXI_WDATA[1];
            // FINISH setting DONE wins over a simultaneous write-1-to-clear
            if (state_q == S_FINISH) begin
                done_q   <= 1'b1;
                result_q <= acc;
            end else if (start_go) begin
                done_q <= 1'b0;
            end else if (wr_fire && wr_dec.sel == SEL_STATUS && S00_AXI_WDATA[1]) begin
                done_q <= 1'b0;
            end
        end
    end

    // Read data mux; START always reads back as zero
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        unique case (rd_dec.sel)
            SEL_CTRL:   rd_data = {29'd0, irq_en_q, mode_q, 1'b0};
            SEL_STATUS: rd_data = {30'd0, done_q, busy};
            SEL_RES_LO: rd_data = result64[31:0];
            SEL_RES_HI: rd_data = result64[63:32];
            SEL_A:      rd_data = 32'(a_mem[rd_dec.idx]);
            SEL_B:      rd_data = 32'(b_mem[rd_dec.idx]);
            default:    rd_resp = RESP_SLVERR;
        endcase
    end

    // Read channel: one-cycle ARREADY, data held until RREADY
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            S00_AXI_ARREADY <= 1'b0;
            S00_AXI_RVALID  <= 1'b0;
            S00_AXI_RDATA   <= '0;
            S00_AXI_RRESP   <= RESP_OKAY;
        end else begin
            S00_AXI_ARREADY <= !S00_AXI_ARREADY && !S00_AXI_RVALID && S00_AXI_ARVALID;
            if (rd_fire) begin
                S00_AXI_RVALID <= 1'b1;
                S00_AXI_RDATA  <= rd_data;
                S00_AXI_RRESP  <= rd_resp;
            end else if (S00_AXI_RVALID && S00_AXI_RREADY) begin
                S00_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dist_engine_axil.sv
// tb/tb_dist_engine_axil.sv - self-checking bench for dist_engine_axil
module tb_dist_engine_axil;

    localparam int DIM    = 8;
    localparam int ELEM_W = 16;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_RLO    = 8'h08;
    localparam logic [7:0] A_RHI    = 8'h0C;
    localparam logic [7:0] A_ELA    = 8'h40;
    localparam logic [7:0] A_ELB    = 8'h80;
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [7:0]  AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [7:0]  ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        IRQ;

    dist_engine_axil #(
        .DIM                  (DIM),
        .ELEM_W               (ELEM_W),
        .C_S00_AXI_DATA_WIDTH (32),
        .C_S00_AXI_ADDR_WIDTH (8)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .S00_AXI_AWADDR  (AWADDR),
        .S00_AXI_AWVALID (AWVALID),
        .S00_AXI_AWREADY (AWREADY),
        .S00_AXI_WDATA   (WDATA),
        .S00_AXI_WSTRB   (WSTRB),
        .S00_AXI_WVALID  (WVALID),
        .S00_AXI_WREADY  (WREADY),
        .S00_AXI_BRESP   (BRESP),
        .S00_AXI_BVALID  (BVALID),
        .S00_AXI_BREADY  (BREADY),
        .S00_AXI_ARADDR  (ARADDR),
        .S00_AXI_ARVALID (ARVALID),
        .S00_AXI_ARREADY (ARREADY),
        .S00_AXI_RDATA   (RDATA),
        .S00_AXI_RRESP   (RRESP),
        .S00_AXI_RVALID  (RVALID),
        .S00_AXI_RREADY  (RREADY),
        .IRQ             (IRQ)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    int irq_cnt = 0;
    int irq_cyc = 0;
    int wr_fire_cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int unsigned a_m [DIM];
    int unsigned b_m [DIM];

    logic [33:0] sb_q [$];
    string       sb_tag [$];

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(negedge ACLK) begin
        if (IRQ) begin
            irq_cnt <= irq_cnt + 1;
            irq_cyc <= cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        AWADDR = addr; WDATA = data; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        while (!AWREADY && n < 16) begin
            @(posedge ACLK); #1; n++;
        end
        @(posedge ACLK); #1;
        wr_fire_cyc = cyc;
        AWVALID = 1'b0; WVALID = 1'b0;
        check("bvalid", 64'(BVALID), 64'd1);
        resp = BRESP;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        while (!ARREADY && n < 16) begin
            @(posedge ACLK); #1; n++;
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        check("rvalid", 64'(RVALID), 64'd1);
        data = RDATA;
        resp = RRESP;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] data, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(addr, data, r);
        check(tag, 64'(r), 64'(exp_resp));
    endtask

    // Expectation goes on the scoreboard first, then the read pops and compares it
    task automatic expect_read(input string tag, input logic [7:0] addr, input logic [1:0] resp, input logic [31:0] data);
        logic [31:0] d;
        logic [1:0]  r;
        logic [33:0] e;
        string       t;
        sb_q.push_back({resp, data});
        sb_tag.push_back(tag);
        axi_read(addr, d, r);
        e = sb_q.pop_front();
        t = sb_tag.pop_front();
        check(t, 64'({r, d}), 64'(e));
    endtask

    task automatic wait_done();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        n = 0;
        do begin
            axi_read(A_STATUS, d, r);
            n++;
        end while (!d[1] && n < 40);
        check("done_poll", 64'(d[1]), 64'd1);
    endtask

    task automatic load_vectors();
        for (int i = 0; i < DIM; i++) begin
            wr("wr_a", A_ELA + 8'(4*i), a_m[i], OKAY);
            wr("wr_b", A_ELB + 8'(4*i), b_m[i], OKAY);
        end
    endtask

    function automatic logic [63:0] model_dist(input bit manhattan);
        logic [63:0] sum, d;
        sum = '0;
        for (int i = 0; i < DIM; i++) begin
            d = (a_m[i] >= b_m[i]) ? 64'(a_m[i] - b_m[i]) : 64'(b_m[i] - a_m[i]);
            sum += manhattan ? d : d * d;
        end
        return sum;
    endfunction

    initial begin
        logic [63:0] exp;
        int irq0, fire0;

        repeat (3) @(posedge ACLK);
        #1;
        check("reset_outputs",
              64'({AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, BRESP, RRESP, IRQ}), 64'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        expect_read("status_rst", A_STATUS, OKAY, 32'd0);
        expect_read("res_lo_rst", A_RLO, OKAY, 32'd0);
        expect_read("ctrl_rst", A_CTRL, OKAY, 32'd0);

        wr("wr_a3_wide", A_ELA + 8'd12, 32'h1234_5678, OKAY);
        expect_read("a3_trunc", A_ELA + 8'd12, OKAY, 32'h0000_5678);
        wr("wr_a_oob", A_ELA + 8'(4*DIM), 32'h55, SLVERR);
        expect_read("rd_a_oob", A_ELA + 8'(4*DIM), SLVERR, 32'd0);
        expect_read("rd_unmapped", 8'h20, SLVERR, 32'd0);

        // Squared Euclidean with IRQ enabled
        for (int i = 0; i < DIM; i++) begin
            a_m[i] = i + 1;
            b_m[i] = i + 5;
        end
        load_vectors();
        exp  = model_dist(1'b0);
        irq0 = irq_cnt;
        wr("start_m0", A_CTRL, 32'h5, OKAY);
        fire0 = wr_fire_cyc;
        wait_done();
        check("irq_count_m0", 64'(irq_cnt - irq0), 64'd1);
        check("finish_latency", 64'(irq_cyc - fire0), 64'(DIM));
        expect_read("res_lo_m0", A_RLO, OKAY, exp[31:0]);
        expect_read("res_hi_m0", A_RHI, OKAY, exp[63:32]);
        expect_read("ctrl_readback", A_CTRL, OKAY, 32'h4);

        // Manhattan; restarting clears DONE while busy
        exp  = model_dist(1'b1);
        irq0 = irq_cnt;
        wr("start_m1", A_CTRL, 32'h7, OKAY);
        expect_read("status_busy", A_STATUS, OKAY, 32'h1);
        wait_done();
        check("irq_count_m1", 64'(irq_cnt - irq0), 64'd1);
        expect_read("res_lo_m1", A_RLO, OKAY, exp[31:0]);
        expect_read("res_hi_m1", A_RHI, OKAY, exp[63:32]);
        expect_read("status_done", A_STATUS, OKAY, 32'h2);
        wr("w1c_done", A_STATUS, 32'h2, OKAY);
        expect_read("status_cleared", A_STATUS, OKAY, 32'h0);
        expect_read("res_hold", A_RLO, OKAY, exp[31:0]);

        // Full-scale operands, IRQ disabled
        for (int i = 0; i < DIM; i++) begin
            a_m[i] = 32'hFFFF;
            b_m[i] = 0;
        end
        load_vectors();
        exp  = model_dist(1'b0);
        irq0 = irq_cnt;
        wr("start_full", A_CTRL, 32'h1, OKAY);
        wait_done();
        check("irq_none_full", 64'(irq_cnt - irq0), 64'd0);
        expect_read("res_lo_full", A_RLO, OKAY, exp[31:0]);
        expect_read("res_hi_full", A_RHI, OKAY, exp[63:32]);

        // Writes while busy are acknowledged but ignored
        for (int i = 0; i < DIM; i++) begin
            a_m[i] = i + 1;
            b_m[i] = i + 5;
        end
        load_vectors();
        exp  = model_dist(1'b0);
        irq0 = irq_cnt;
        wr("start_busy_run", A_CTRL, 32'h5, OKAY);
        wr("wr_a0_busy", A_ELA, 32'd9, OKAY);
        wr("start_while_busy", A_CTRL, 32'h7, OKAY);
        wait_done();
        repeat (3 * DIM) @(posedge ACLK);
        #1;
        check("irq_single_run", 64'(irq_cnt - irq0), 64'd1);
        expect_read("res_lo_busy", A_RLO, OKAY, exp[31:0]);
        expect_read("a0_unchanged", A_ELA, OKAY, a_m[0]);
        expect_read("ctrl_unchanged", A_CTRL, OKAY, 32'h4);
        expect_read("status_no_rerun", A_STATUS, OKAY, 32'h2);

        // Reset in the middle of a run
        irq0 = irq_cnt;
        wr("start_abort", A_CTRL, 32'h5, OKAY);
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        repeat (DIM + 4) @(posedge ACLK);
        #1;
        check("irq_after_abort", 64'(irq_cnt - irq0), 64'd0);
        expect_read("status_abort", A_STATUS, OKAY, 32'd0);
        expect_read("res_lo_abort", A_RLO, OKAY, 32'd0);
        expect_read("res_hi_abort", A_RHI, OKAY, 32'd0);
        expect_read("a1_cleared", A_ELA + 8'd4, OKAY, 32'd0);
        expect_read("rd_0xfc", 8'hFC, SLVERR, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
